// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared encodings and bus widths for the execute-stage multiply sequencer.
// Covers the op codes, the sequencer states and the 64-bit HI:LO bus widths.
package mul_hilo_ctrl_pkg;

  localparam int unsigned MUL_DATA_W          = 32;
  localparam int unsigned DOUBLE_REG_DATA_BUS = 2 * MUL_DATA_W;

  typedef enum logic [2:0] {
    MULOP_NONE  = 3'b000,
    MULOP_MULT  = 3'b001,
    MULOP_MULTU = 3'b010,
    MULOP_MUL   = 3'b011,
    MULOP_MADD  = 3'b100,
    MULOP_MADDU = 3'b101,
    MULOP_MSUB  = 3'b110,
    MULOP_MSUBU = 3'b111
  } mul_op_e;

  typedef enum logic [1:0] {
    MULC_IDLE = 2'b00,
    MULC_WAIT = 2'b01,
    MULC_ACC  = 2'b10,
    MULC_DONE = 2'b11
  } mulc_state_e;

  // Result beat payload for the HI/LO write path.
  typedef struct packed {
    logic [MUL_DATA_W-1:0] hi;
    logic [MUL_DATA_W-1:0] lo;
  } mul_hilo_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    case (op)
      MULOP_MULT, MULOP_MUL, MULOP_MADD, MULOP_MSUB: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_fa64.sv
// Full-width adder/subtractor used for the HI:LO accumulate step.
// Subtraction is a + ~b + 1, so the result wraps modulo 2^W.
module mul_hilo_ctrl_fa64 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         is_sub_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {W{is_sub_i}}) + W'(is_sub_i);

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Execute-stage sequencer for the two-stage multiplier: issues the op, stalls the
// pipe while it runs, performs the HI:LO accumulate step and returns one result beat.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  OP_VALID,
  input  logic [2:0]            OP,
  input  logic [DATA_W-1:0]     SRC_A,
  input  logic [DATA_W-1:0]     SRC_B,
  input  logic [DATA_W-1:0]     HI_IN,
  input  logic [DATA_W-1:0]     LO_IN,
  input  logic                  FLUSH,
  output logic                  MUL_SIGNED,
  output logic [DATA_W-1:0]     MUL_A,
  output logic [DATA_W-1:0]     MUL_B,
  output logic                  MUL_START,
  output logic                  MUL_CANCEL,
  input  logic [2*DATA_W-1:0]   MUL_RESULT,
  input  logic                  MUL_READY,
  output logic                  STALL_REQ,
  output logic                  RESULT_VALID,
  output logic                  WRITE_HILO,
  output logic                  WRITE_GPR,
  output logic [DATA_W-1:0]     HI_OUT,
  output logic [DATA_W-1:0]     LO_OUT,
  output logic [DATA_W-1:0]     GPR_OUT
);

  localparam int unsigned DW2 = 2 * DATA_W;

  mulc_state_e            state_q;
  mul_op_e                op_q;
  logic [DW2-1:0]         hilo_q;
  logic [DW2-1:0]         prod_q;
  logic [DW2-1:0]         acc_d;
  mul_hilo_t              res_q;
  logic [DATA_W-1:0]      gpr_q;
  logic                   issue_c;
  logic                   done_c;

  // Issue only from IDLE with a real op and no flush in flight.
  assign issue_c = (state_q == MULC_IDLE) & OP_VALID & (OP != 3'b000) & ~FLUSH;
  assign done_c  = (state_q == MULC_DONE) & ~FLUSH;

  assign MUL_SIGNED = op_is_signed(OP);
  assign MUL_A      = SRC_A;
  assign MUL_B      = SRC_B;
  assign MUL_START  = issue_c;
  assign MUL_CANCEL = FLUSH;

  assign STALL_REQ = ~FLUSH & (issue_c | (state_q == MULC_WAIT) | (state_q == MULC_ACC));

  assign RESULT_VALID = done_c;
  assign WRITE_GPR    = done_c & (op_q == MULOP_MUL);
  assign WRITE_HILO   = done_c & (op_q != MULOP_MUL);

  assign HI_OUT  = res_q.hi;
  assign LO_OUT  = res_q.lo;
  assign GPR_OUT = gpr_q;

  // Latched HI:LO plus or minus the captured product.
  mul_hilo_ctrl_fa64 #(.W(DW2)) u_fa64 (
    .a_i      (hilo_q),
    .b_i      (prod_q),
    .is_sub_i (op_is_sub(op_q)),
    .sum_o    (acc_d)
  );

  // Sequencer state, operand latches and the held result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= MULC_IDLE;
      op_q    <= MULOP_NONE;
      hilo_q  <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      gpr_q   <= '0;
    end else begin
      case (state_q)
        MULC_IDLE: begin
          if (issue_c) begin
            op_q    <= mul_op_e'(OP);
            hilo_q  <= {HI_IN, LO_IN};
            state_q <= MULC_WAIT;
          end
        end
        MULC_WAIT: begin
          if (FLUSH) begin
            state_q <= MULC_IDLE;
          end else if (MUL_READY) begin
            prod_q <= MUL_RESULT;
            if (op_is_acc(op_q)) begin
              state_q <= MULC_ACC;
            end else begin
              state_q <= MULC_DONE;
              if (op_q == MULOP_MUL) begin
                gpr_q <= MUL_RESULT[DATA_W-1:0];
              end else begin
                res_q <= MUL_RESULT;
              end
            end
          end
        end
        MULC_ACC: begin
          if (FLUSH) begin
            state_q <= MULC_IDLE;
          end else begin
            res_q   <= acc_d;
            state_q <= MULC_DONE;
          end
        end
        MULC_DONE: begin
          // The issuing instruction leaves EX this cycle; the next op issues from IDLE.
          state_q <= MULC_IDLE;
        end
        default: begin
          state_q <= MULC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a behavioural multiplier of adjustable
// latency and a scoreboard of expected result beats.
module tb_mul_hilo_ctrl;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  logic        CLK, RST, OP_VALID, FLUSH;
  logic [2:0]  OP;
  logic [31:0] SRC_A, SRC_B, HI_IN, LO_IN;
  logic        MUL_SIGNED, MUL_START, MUL_CANCEL, MUL_READY;
  logic [31:0] MUL_A, MUL_B;
  logic [63:0] MUL_RESULT;
  logic        STALL_REQ, RESULT_VALID, WRITE_HILO, WRITE_GPR;
  logic [31:0] HI_OUT, LO_OUT, GPR_OUT;

  mul_hilo_ctrl #(.DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .OP_VALID(OP_VALID), .OP(OP),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .HI_IN(HI_IN), .LO_IN(LO_IN), .FLUSH(FLUSH),
    .MUL_SIGNED(MUL_SIGNED), .MUL_A(MUL_A), .MUL_B(MUL_B),
    .MUL_START(MUL_START), .MUL_CANCEL(MUL_CANCEL),
    .MUL_RESULT(MUL_RESULT), .MUL_READY(MUL_READY),
    .STALL_REQ(STALL_REQ), .RESULT_VALID(RESULT_VALID),
    .WRITE_HILO(WRITE_HILO), .WRITE_GPR(WRITE_GPR),
    .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .GPR_OUT(GPR_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        whilo;
    logic        wgpr;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] gpr;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] ehi, elo, egpr;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'd0, a};
    xb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return xa * xb;
  endfunction

  function automatic logic exp_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic exp_t ref_exp(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] hi,
                                   input logic [31:0] lo);
    exp_t e;
    logic [63:0] p, r;
    p = mul_model(a, b, exp_signed(op));
    if (op == OP_MADD || op == OP_MADDU) r = {hi, lo} + p;
    else if (op == OP_MSUB || op == OP_MSUBU) r = {hi, lo} - p;
    else r = p;
    e.whilo = (op != OP_MUL);
    e.wgpr  = (op == OP_MUL);
    e.hi    = r[63:32];
    e.lo    = r[31:0];
    e.gpr   = p[31:0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: READY pulses 1 + mul_extra cycles after START.
  int   mul_extra = 0;
  int   mul_cnt;
  logic mul_busy;
  always @(posedge CLK) begin
    if (RST || MUL_CANCEL) begin
      mul_busy  <= 1'b0;
      MUL_READY <= 1'b0;
    end else if (MUL_START) begin
      MUL_RESULT <= mul_model(MUL_A, MUL_B, MUL_SIGNED);
      if (mul_extra == 0) begin
        MUL_READY <= 1'b1;
      end else begin
        MUL_READY <= 1'b0;
        mul_busy  <= 1'b1;
        mul_cnt   <= mul_extra;
      end
    end else if (mul_busy) begin
      if (mul_cnt == 1) begin
        mul_busy  <= 1'b0;
        MUL_READY <= 1'b1;
      end
      mul_cnt <= mul_cnt - 1;
    end else begin
      MUL_READY <= 1'b0;
    end
  end

  // Scoreboard: every result beat must match the oldest pending expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b0 && RESULT_VALID === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result hi=%h lo=%h gpr=%h", HI_OUT, LO_OUT, GPR_OUT);
      end else begin
        e = sb_q.pop_front();
        if (WRITE_HILO !== e.whilo || WRITE_GPR !== e.wgpr ||
            (e.whilo && {HI_OUT, LO_OUT} !== {e.hi, e.lo}) ||
            (e.wgpr && GPR_OUT !== e.gpr)) begin
          errors++;
          $display("FAIL result_beat actual whilo=%b wgpr=%b hi=%h lo=%h gpr=%h required whilo=%b wgpr=%b hi=%h lo=%h gpr=%h",
                   WRITE_HILO, WRITE_GPR, HI_OUT, LO_OUT, GPR_OUT,
                   e.whilo, e.wgpr, e.hi, e.lo, e.gpr);
        end
      end
    end
  end

  // Issue one op at the current cycle, hold it in EX until the result beat.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input exp_t e,
                        input string name);
    int lat;
    bit done;
    bit stall_ok;
    int exp_lat;
    exp_lat = 2 + (op[2] ? 1 : 0) + mul_extra;
    OP_VALID = 1'b1; OP = op; SRC_A = a; SRC_B = b; HI_IN = hi; LO_IN = lo; FLUSH = 1'b0;
    sb_q.push_back(e);
    @(negedge CLK);
    chk({name, "_start"}, 64'(MUL_START), 64'd1);
    chk({name, "_signed"}, 64'(MUL_SIGNED), 64'(exp_signed(op)));
    stall_ok = (STALL_REQ === 1'b1);
    lat = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (RESULT_VALID === 1'b1) done = 1'b1;
      else if (STALL_REQ !== 1'b1) stall_ok = 1'b0;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_stall"}, {62'd0, stall_ok, STALL_REQ}, 64'd2);
    @(posedge CLK); #1;
    OP_VALID = 1'b0; OP = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [2:0]  rop;
    logic [31:0] ra, rb, rhi, rlo;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 32'h0};
    vecs[2] = '{OP_MADD,  32'h00000003, 32'h00000004, 32'h0, 32'h5, 32'h00000000, 32'h00000011, 32'h0};
    vecs[3] = '{OP_MSUBU, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    vecs[4] = '{OP_MUL,   32'h00010000, 32'h00010003, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00030000};
    vecs[5] = '{OP_MSUB,  32'hFFFFFFFE, 32'h00000003, 32'h0, 32'hA, 32'h00000000, 32'h00000010, 32'h0};
    vecs[6] = '{OP_MADDU, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 32'h0};
    vecs[8] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 32'h0};
    vecs[9] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};

    RST = 1'b1; OP_VALID = 1'b0; OP = OP_NONE; FLUSH = 1'b0;
    SRC_A = '0; SRC_B = '0; HI_IN = '0; LO_IN = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", 64'(RESULT_VALID), 64'd0);
    chk("rst_wen", {62'd0, WRITE_HILO, WRITE_GPR}, 64'd0);
    chk("rst_stall", 64'(STALL_REQ), 64'd0);
    chk("rst_data", {HI_OUT, LO_OUT}, 64'd0);
    chk("rst_gpr", 64'(GPR_OUT), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Table vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      e.whilo = (vecs[i].op != OP_MUL);
      e.wgpr  = (vecs[i].op == OP_MUL);
      e.hi    = vecs[i].ehi;
      e.lo    = vecs[i].elo;
      e.gpr   = vecs[i].egpr;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, e, $sformatf("vec%0d", i));
    end

    // OP=000 with OP_VALID is not an issue.
    OP_VALID = 1'b1; OP = OP_NONE;
    @(negedge CLK);
    chk("opnone_start", 64'(MUL_START), 64'd0);
    chk("opnone_stall", 64'(STALL_REQ), 64'd0);
    @(posedge CLK); #1;
    OP_VALID = 1'b0;

    // Flush on the issue cycle.
    OP_VALID = 1'b1; OP = OP_MADD; SRC_A = 32'd7; SRC_B = 32'd9; FLUSH = 1'b1;
    @(negedge CLK);
    chk("flush_issue_start", 64'(MUL_START), 64'd0);
    chk("flush_issue_cancel", 64'(MUL_CANCEL), 64'd1);
    chk("flush_issue_stall", 64'(STALL_REQ), 64'd0);
    @(posedge CLK); #1;
    OP_VALID = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    chk("flush_issue_idle", 64'(STALL_REQ), 64'd0);
    @(posedge CLK); #1;

    // Flush in the WAIT cycle of a MADD.
    OP_VALID = 1'b1; OP = OP_MADD; SRC_A = 32'd3; SRC_B = 32'd4; HI_IN = 32'd1; LO_IN = 32'd2;
    @(posedge CLK); #1;
    FLUSH = 1'b1;
    @(negedge CLK);
    chk("flush_wait_stall", 64'(STALL_REQ), 64'd0);
    chk("flush_wait_cancel", 64'(MUL_CANCEL), 64'd1);
    @(posedge CLK); #1;
    FLUSH = 1'b0; OP_VALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("flush_wait_quiet%0d", k), {62'd0, RESULT_VALID, STALL_REQ}, 64'd0);
    end
    @(posedge CLK); #1;

    // Flush in the DONE cycle of a MULT.
    OP_VALID = 1'b1; OP = OP_MULT; SRC_A = 32'd5; SRC_B = 32'd6;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    FLUSH = 1'b1;
    @(negedge CLK);
    chk("flush_done_valid", 64'(RESULT_VALID), 64'd0);
    chk("flush_done_wen", {62'd0, WRITE_HILO, WRITE_GPR}, 64'd0);
    @(posedge CLK); #1;
    FLUSH = 1'b0; OP_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_done_idle", {62'd0, RESULT_VALID, STALL_REQ}, 64'd0);
    @(posedge CLK); #1;

    // Make HI/LO/GPR non-zero, then reset in the ACC cycle of a MADD.
    run_op(OP_MUL, 32'h00000123, 32'h00000010, 32'h0, 32'h0,
           ref_exp(OP_MUL, 32'h00000123, 32'h00000010, 32'h0, 32'h0), "pre_rst_mul");
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0,
           ref_exp(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0), "pre_rst_mult");
    OP_VALID = 1'b1; OP = OP_MADD; SRC_A = 32'd3; SRC_B = 32'd4; HI_IN = 32'd1; LO_IN = 32'd2;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1; OP_VALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("acc_rst_flags", {60'd0, RESULT_VALID, WRITE_HILO, WRITE_GPR, STALL_REQ}, 64'd0);
    chk("acc_rst_hilo", {HI_OUT, LO_OUT}, 64'd0);
    chk("acc_rst_gpr", 64'(GPR_OUT), 64'd0);
    @(posedge CLK); #1;

    // Back-to-back MULT right after reset recovery.
    run_op(OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'h0, 32'h0,
           ref_exp(OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'h0, 32'h0), "post_rst_mult");

    // Random ops with stretched multiplier latency.
    for (int i = 0; i < 16; i++) begin
      mul_extra = $urandom_range(0, 2);
      rop = 3'($urandom_range(1, 7));
      ra  = $urandom; rb = $urandom; rhi = $urandom; rlo = $urandom;
      run_op(rop, ra, rb, rhi, rlo, ref_exp(rop, ra, rb, rhi, rlo), $sformatf("rnd%0d", i));
    end
    mul_extra = 0;

    @(negedge CLK);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
